// File: rtl/pim_conv_ctrl.sv
// pim_conv_ctrl: initiator-side sequencer for the conv PIM crossbar wrapper.
// Takes one feature vector per transaction, issues crossbar addresses
// 0..NUM_ADDR-1 one per cycle, accumulates every ADC result after PIM_LAT
// cycles, and returns the sum downstream.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_feature   feature vector input handshake
//   pim_feature/pim_addr/pim_en    drive into conv
//   pim_result                     ADC result from conv
//   out_valid/out_ready/out_data   accumulated sum output handshake
//   busy                           high whenever not idle
module pim_conv_ctrl #(
   parameter int unsigned CROSS_SIZE = 64,
   parameter int unsigned DEPTH      = 6,
   parameter int unsigned ADC_P      = 8,
   parameter int unsigned NUM_ADDR   = 64,
   parameter int unsigned PIM_LAT    = 1,
   parameter int unsigned ACC_W      = ADC_P + DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CROSS_SIZE-1:0] in_feature,
   output logic [CROSS_SIZE-1:0] pim_feature,
   output logic [DEPTH-1:0]      pim_addr,
   output logic                  pim_en,
   input  logic [ADC_P-1:0]      pim_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic                  busy
);

   localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(NUM_ADDR - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [CROSS_SIZE-1:0] feat_q, feat_d;
   logic [DEPTH-1:0]      addr_q, addr_d;
   logic                  en_q, en_d;
   logic [PIM_LAT-1:0]    tag_q, tag_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [ACC_W-1:0]      out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  in_ready_q, in_ready_d;

   // Next-state, issue counter, tag pipeline and accumulator
   always_comb begin
      state_d    = state_q;
      feat_d     = feat_q;
      addr_d     = addr_q;
      en_d       = 1'b0;
      out_data_d = out_data_q;
      // tag_q[PIM_LAT-1] marks the cycle in which an issued result is on pim_result
      tag_d      = PIM_LAT'({tag_q, en_q});
      acc_d      = acc_q;
      if (tag_q[PIM_LAT-1]) begin
         acc_d = acc_q + ACC_W'(pim_result);
      end

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               feat_d  = in_feature;
               acc_d   = '0;
               addr_d  = '0;
               en_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + DEPTH'(1);
               en_d   = 1'b1;
            end
         end
         DRAIN: begin
            // Leave once the last outstanding result is being folded in this cycle
            if (tag_d == '0) begin
               out_data_d = acc_d;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         feat_q      <= '0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         tag_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         feat_q      <= feat_d;
         addr_q      <= addr_d;
         en_q        <= en_d;
         tag_q       <= tag_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign pim_feature = feat_q;
   assign pim_addr    = addr_q;
   assign pim_en      = en_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_pim_conv_ctrl.sv
// Testbench for pim_conv_ctrl: a default instance (64 addresses, latency 1)
// and a variant (16 addresses, latency 3), each fed by a behavioural PIM model.
module tb_pim_conv_ctrl;

   localparam int N_A = 64;
   localparam int L_A = 1;
   localparam int N_B = 16;
   localparam int L_B = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_feature;
   logic        in_valid    [2];
   logic        in_ready_o  [2];
   logic [63:0] pim_feat_o  [2];
   logic [5:0]  pim_addr_o  [2];
   logic        pim_en_o    [2];
   logic [7:0]  pim_res     [2];
   logic        out_valid_o [2];
   logic        out_ready   [2];
   logic [13:0] out_data_o  [2];
   logic        busy_o      [2];

   int          vectors = 0;
   int          miscompares = 0;
   int          mode [2];
   logic [7:0]  rnd_tbl [64];
   logic        en_h [2][3];
   logic [5:0]  ad_h [2][3];
   logic [7:0]  junk [2];

   always #5 clk = ~clk;

   pim_conv_ctrl u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready_o[0]), .in_feature(in_feature),
      .pim_feature(pim_feat_o[0]), .pim_addr(pim_addr_o[0]), .pim_en(pim_en_o[0]),
      .pim_result(pim_res[0]),
      .out_valid(out_valid_o[0]), .out_ready(out_ready[0]), .out_data(out_data_o[0]),
      .busy(busy_o[0])
   );

   pim_conv_ctrl #(.NUM_ADDR(N_B), .PIM_LAT(L_B)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready_o[1]), .in_feature(in_feature),
      .pim_feature(pim_feat_o[1]), .pim_addr(pim_addr_o[1]), .pim_en(pim_en_o[1]),
      .pim_result(pim_res[1]),
      .out_valid(out_valid_o[1]), .out_ready(out_ready[1]), .out_data(out_data_o[1]),
      .busy(busy_o[1])
   );

   // Crossbar content seen at an address under each model mode
   function automatic logic [7:0] xbar(input int m, input logic [5:0] a, input logic [7:0] r);
      case (m)
         0:       return 8'(a);
         1:       return 8'hff;
         2:       return 8'(a) + 8'd1;
         default: return r;
      endcase
   endfunction

   // PIM model: result of an issue appears exactly L cycles later; garbage otherwise
   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         en_h[s][0] <= pim_en_o[s];
         ad_h[s][0] <= pim_addr_o[s];
         for (int k = 1; k < 3; k++) begin
            en_h[s][k] <= en_h[s][k-1];
            ad_h[s][k] <= ad_h[s][k-1];
         end
         junk[s] <= 8'($urandom);
      end
   end

   assign pim_res[0] = en_h[0][L_A-1] ? xbar(mode[0], ad_h[0][L_A-1], rnd_tbl[ad_h[0][L_A-1]]) : junk[0];
   assign pim_res[1] = en_h[1][L_B-1] ? xbar(mode[1], ad_h[1][L_B-1], rnd_tbl[ad_h[1][L_B-1]]) : junk[1];

   function automatic logic [13:0] ref_sum(input int m, input int n);
      logic [13:0] s = '0;
      for (int a = 0; a < n; a++) s += 14'(xbar(m, 6'(a), rnd_tbl[a]));
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance sel, optionally holding out_ready low for bp cycles
   task automatic run_txn(input int sel, input int n, input int lat, input int bp);
      logic [63:0] feat;
      logic [13:0] exp_sum;
      logic [13:0] held;
      int          issues;
      int          first_ov;
      bit          addr_ok;
      bit          feat_ok;
      bit          busy_ok;
      feat     = {$urandom, $urandom};
      exp_sum  = ref_sum(mode[sel], n);
      issues   = 0;
      first_ov = 0;
      addr_ok  = 1'b1;
      feat_ok  = 1'b1;
      busy_ok  = 1'b1;
      out_ready[sel] = (bp == 0);
      @(negedge clk);
      in_valid[sel] = 1'b1;
      in_feature    = feat;
      @(posedge clk);
      for (int j = 1; j <= 400; j++) begin
         @(negedge clk);
         if (j == 1) begin
            in_valid[sel] = 1'b0;
            in_feature    = {$urandom, $urandom};
         end
         if (busy_o[sel] !== 1'b1 || in_ready_o[sel] !== 1'b0) busy_ok = 1'b0;
         if (pim_feat_o[sel] !== feat) feat_ok = 1'b0;
         if (pim_en_o[sel] === 1'b1) begin
            if (pim_addr_o[sel] !== 6'(issues)) addr_ok = 1'b0;
            issues++;
         end
         if (out_valid_o[sel] === 1'b1) begin
            first_ov = j;
            break;
         end
      end
      check("issue_count", 64'(issues), 64'(n));
      check("addr_sequence", 64'(addr_ok), 64'd1);
      check("feature_stable", 64'(feat_ok), 64'd1);
      check("busy_during_txn", 64'(busy_ok), 64'd1);
      check("out_valid_latency", 64'(first_ov), 64'(n + lat + 1));
      check("out_data", 64'(out_data_o[sel]), 64'(exp_sum));
      held = out_data_o[sel];
      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid_o[sel]), 64'd1);
         check("bp_out_data", 64'(out_data_o[sel]), 64'(held));
         check("bp_in_ready", 64'(in_ready_o[sel]), 64'd0);
         check("bp_pim_en", 64'(pim_en_o[sel]), 64'd0);
      end
      out_ready[sel] = 1'b1;
      @(negedge clk);
      check("post_out_valid", 64'(out_valid_o[sel]), 64'd0);
      check("post_in_ready", 64'(in_ready_o[sel]), 64'd1);
      check("post_busy", 64'(busy_o[sel]), 64'd0);
   endtask

   initial begin
      bit found;
      rst          = 1'b1;
      in_feature   = '0;
      in_valid[0]  = 1'b0;
      in_valid[1]  = 1'b0;
      out_ready[0] = 1'b1;
      out_ready[1] = 1'b1;
      mode[0]      = 0;
      mode[1]      = 2;
      for (int a = 0; a < 64; a++) rnd_tbl[a] = 8'($urandom);
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 3; k++) begin
            en_h[s][k] = 1'b0;
            ad_h[s][k] = '0;
         end

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("rst_pim_en", 64'(pim_en_o[s]), 64'd0);
         check("rst_pim_addr", 64'(pim_addr_o[s]), 64'd0);
         check("rst_pim_feature", pim_feat_o[s], 64'd0);
         check("rst_out_valid", 64'(out_valid_o[s]), 64'd0);
         check("rst_out_data", 64'(out_data_o[s]), 64'd0);
         check("rst_busy", 64'(busy_o[s]), 64'd0);
         check("rst_in_ready", 64'(in_ready_o[s]), 64'd1);
      end

      // Ramp, all-max, and backpressure on the default instance
      mode[0] = 0;
      run_txn(0, N_A, L_A, 0);
      mode[0] = 1;
      run_txn(0, N_A, L_A, 0);
      mode[0] = 0;
      run_txn(0, N_A, L_A, 10);

      // Reset while issuing address 20
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_feature  = {$urandom, $urandom};
      @(posedge clk);
      found = 1'b0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         in_valid[0] = 1'b0;
         if (pim_en_o[0] === 1'b1 && pim_addr_o[0] === 6'd20) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_addr20", 64'(found), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_pim_en", 64'(pim_en_o[0]), 64'd0);
      check("midrst_in_ready", 64'(in_ready_o[0]), 64'd1);
      check("midrst_out_valid", 64'(out_valid_o[0]), 64'd0);
      check("midrst_busy", 64'(busy_o[0]), 64'd0);
      rst = 1'b0;
      run_txn(0, N_A, L_A, 0);

      // Variant instance: addr+1 with 3-cycle latency
      mode[1] = 2;
      run_txn(1, N_B, L_B, 0);

      // Random crossbar contents with random backpressure on both instances
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < 64; a++) rnd_tbl[a] = 8'($urandom_range(0, 255));
         mode[r % 2] = 3;
         if (r % 2 == 0) run_txn(0, N_A, L_A, int'($urandom_range(0, 4)));
         else            run_txn(1, N_B, L_B, int'($urandom_range(0, 4)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pim_conv_ctrl.md
Name: pim_conv_ctrl

Overview:
- Initiator-side sequencer for the `conv` PIM crossbar wrapper.
- Accepts one input-feature vector per transaction via valid/ready.
- Sweeps crossbar addresses 0..NUM_ADDR-1, driving feature/address/enable into `conv`, one issue per cycle.
- Captures each ADC result after a fixed PIM latency, accumulates all results, and returns the sum downstream via valid/ready.

Parameters:
- CROSS_SIZE, 64, feature vector width; equals crossbar input count.
- DEPTH, 6, address width driven to `conv`.
- ADC_P, 8, ADC result width returned by `conv`.
- NUM_ADDR, 64, addresses swept per transaction; legal range 1..2^DEPTH.
- PIM_LAT, 1, cycles from issue (pim_en high) to the corresponding valid pim_result; legal range ≥1.
- ACC_W, ADC_P+DEPTH, accumulator/output width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, feature vector valid.
- in_ready, output, 1, controller can accept a vector.
- in_feature, input, CROSS_SIZE, feature vector.
- pim_feature, output, CROSS_SIZE, to `conv` Input_feature.
- pim_addr, output, DEPTH, to `conv` Address.
- pim_en, output, 1, to `conv` en; one issue per high cycle.
- pim_result, input, ADC_P, from `conv` Output.
- out_valid, output, 1, accumulated result valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, ACC_W, accumulated sum.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - State goes to IDLE.
  - Reset values: pim_en=0, pim_addr=0, pim_feature=0, out_valid=0, out_data=0, busy=0, in_ready=1.
  - Latency pipeline flushed; accumulator cleared.
  - Reset mid-operation discards all in-flight issues and results; no partial result is ever emitted.
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge T: latch in_feature into feature register (drives pim_feature), clear accumulator, set addr counter=0, go to ISSUE.
- ISSUE:
  - pim_en=1 and pim_addr=counter on cycles T+1 .. T+NUM_ADDR.
  - Counter increments each cycle.
  - After issuing addr NUM_ADDR-1, go to DRAIN.
  - pim_feature holds stable for the whole transaction.
- Valid-tag pipeline:
  - PIM_LAT-deep shift of pim_en.
  - When the tag emerges, pim_result is added to the accumulator in that cycle.
  - A result for an issue at cycle t is sampled at cycle t+PIM_LAT.
- DRAIN:
  - pim_en=0, pim_addr returns to 0.
  - Stay until the tag pipeline is empty and the final result is accumulated, then go to DONE.
- DONE:
  - out_valid=1, out_data=accumulator; both held stable until out_ready.
  - On out_valid&out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready=0 throughout DONE, so no overlap of transactions.
- Latency: accept edge T → out_valid first high at cycle T+NUM_ADDR+PIM_LAT+1. Defaults: 66 cycles.
- Arithmetic:
  - Unsigned zero-extended pim_result summed into ACC_W bits.
  - No overflow possible, since NUM_ADDR·(2^ADC_P−1) < 2^ACC_W; no saturation logic.
- Boundary cases:
  - NUM_ADDR=1: exactly one issue at T+1.
  - Address counter never exceeds NUM_ADDR-1; no wrap.
  - in_valid outside IDLE is ignored; upstream holds it.
  - pim_result is ignored when no tag is present.

Test Plan:
1. Reset: hold rst 3 cycles, then release → all outputs 0 except in_ready=1; busy=0; pim_en=0.
2. Ramp, defaults. PIM model returns pim_result=addr with 1-cycle latency; send one vector, out_ready=1.
   - Required: pim_en high for exactly 64 cycles with addr 0..63, pim_feature constant.
   - Required: out_valid at T+66 with out_data=2016; one-cycle pulse.
3. Max value, defaults. Model returns 255 for every address → out_data=16320, with no wrap in 14 bits.
4. Backpressure. Hold out_ready=0 for 10 cycles after out_valid.
   - Required: out_valid/out_data stable, in_ready=0, pim_en=0.
   - Required: after out_ready=1, out_valid=0 and in_ready=1 on the next cycle.
5. Reset mid-ISSUE. Assert rst at addr 20.
   - Required next cycle: pim_en=0, in_ready=1, out_valid=0.
   - Then send a new vector with the ramp model: out_data=2016, with no stale contribution.
6. Parameter variant, NUM_ADDR=16, PIM_LAT=3. Model returns addr+1 with 3-cycle latency → out_valid at T+20, out_data=136.
